sqrt_square_recon: RTL and testbench
====================================

// Module: sqrt_square_recon
// PURPOSE
//  Inverse of the integer square-root unit: takes a root q and remainder and
//  rebuilds radical = q*q + remainder with a sequential shift-add multiplier.
//  Also flags whether the pair is a canonical sqrt result (remainder <= 2*q).
//  Sits downstream of the sqrt block for self-checking, and serves any path
//  that must re-expand a root. Valid/ready handshake on both sides.
// PARAMETERS
//  Q_W   8        root width; remainder width is Q_W+1; radical width is 2*Q_W+1
//  CNT_W 4        step-counter width; must satisfy 2**CNT_W > Q_W
// PORTS
//  clk        in   1        single clock; all state changes on rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        q/remainder valid
//  in_ready   out  1        block can accept an operand pair
//  q          in   Q_W      root operand
//  remainder  in   Q_W+1    remainder operand
//  out_valid  out  1        radical/canonical valid
//  out_ready  in   1        consumer accepts result
//  radical    out  2*Q_W+1  q*q + remainder, unsigned, never truncated
//  canonical  out  1        1 when remainder <= 2*q (legal sqrt remainder)
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, acc=0, count=0, radical=0,
//    canonical=0, out_valid=0. in_ready=1 once rst deasserts.
//  - FSM: IDLE -> MUL -> DONE -> IDLE.
//    IDLE: in_ready=1. On edge with in_valid&&in_ready: latch q into mcand,
//      shift reg = q, acc = zero-extended remainder, canonical_r =
//      (remainder <= {q,1'b0}), count=0, go MUL.
//    MUL: in_ready=0. Each edge: if shreg[0], acc += mcand << count;
//      shreg >>= 1; count++. Edge where count==Q_W-1 performs last step, go DONE.
//    DONE: out_valid=1, radical=acc, canonical=canonical_r, held stable until
//      out_ready=1 on an edge, then go IDLE (out_valid=0 next cycle).
//  - Latency: acceptance edge t0 -> out_valid high after edge t0+Q_W.
//    Throughput: one result per Q_W+2 cycles with out_ready tied high.
//  - No new input accepted in MUL or DONE (in_ready=0); no bypass IDLE->IDLE.
//  - Arithmetic: acc is 2*Q_W+1 bits; max q=2^Q_W-1, remainder=2^(Q_W+1)-1
//    gives 2^(2*Q_W) exactly (e.g. 65536 for Q_W=8); no overflow possible.
//  - q=0: runs full Q_W steps anyway; radical=remainder, canonical=(remainder==0).
//  - in_valid while busy: ignored, operands not sampled; source must hold.
//  - out_ready high while out_valid low: no effect.
//  - rst mid-MUL or mid-DONE: operation discarded, no out_valid pulse emitted,
//    outputs return to reset values immediately.
//  - Inputs q/remainder are don't-care except on the acceptance edge.
// TESTING
//  1 q=2,r=0 then q=2,r=2 then q=3,r=0 -> radical 4,6,9; canonical 1,1,1.
//  2 q=12,r=0 -> 144; q=146,r=233 -> 21549, canonical=1; out_valid exactly
//    Q_W cycles after acceptance edge, in_ready low from accept to DONE exit.
//  3 q=255,r=511 -> radical=65536 (bit16 set), canonical=0; q=5,r=11 ->
//    36, canonical=0; q=5,r=10 -> 35, canonical=1; q=0,r=0 -> 0, canonical=1.
//  4 Backpressure: out_ready=0 for 10 cycles after out_valid -> radical and
//    canonical stable, in_ready=0, toggling in_valid/q has no effect; release
//    -> single handshake, then IDLE.
//  5 Assert rst at cycle 3 of MUL -> out_valid never rises, radical=0,
//    in_ready=1 after release; next pair q=7,r=3 -> 52 correct.
//  6 Random 2000 pairs, random in_valid/out_ready gaps -> radical==q*q+r and
//    canonical==(r<=2q) for every result, in order, none lost or duplicated.

Source files
------------

// File: rtl/sqrt_square_recon.sv
// sqrt_square_recon: rebuilds radical = q*q + remainder from an integer
// square-root result using a sequential shift-add multiplier, and flags
// whether (q, remainder) is a canonical sqrt pair (remainder <= 2*q).
module sqrt_square_recon #(
    parameter int unsigned Q_W   = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q_W-1:0]   q,
    input  logic [Q_W:0]     remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*Q_W:0]   radical,
    output logic             canonical
);

    localparam int unsigned R_W   = Q_W + 1;
    localparam int unsigned ACC_W = 2 * Q_W + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(Q_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [Q_W-1:0]     mcand_q;
    logic [Q_W-1:0]     shreg_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   count_q;
    logic               canon_q;
    logic [ACC_W-1:0]   radical_q;
    logic               canonical_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic [R_W-1:0]     twice_q_c;

    assign twice_q_c = {q, 1'b0};

    // One multiplier step: add the shifted multiplicand when the current bit is set
    always_comb begin
        acc_d = acc_q;
        if (shreg_q[0]) begin
            acc_d = acc_q + (ACC_W'(mcand_q) << count_q);
        end
    end

    // Control FSM plus datapath registers; outputs are all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            shreg_q     <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            canon_q     <= 1'b0;
            radical_q   <= '0;
            canonical_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mcand_q    <= q;
                        shreg_q    <= q;
                        acc_q      <= ACC_W'(remainder);
                        canon_q    <= (remainder <= twice_q_c);
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q >> 1;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LAST_STEP) begin
                        radical_q   <= acc_d;
                        canonical_q <= canon_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign radical   = radical_q;
    assign canonical = canonical_q;

endmodule

// File: tb/tb_sqrt_square_recon.sv
// Directed and randomized self-checking bench for sqrt_square_recon (Q_W=8).
module tb_sqrt_square_recon;

    localparam int unsigned Q_W = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    q;
    logic [8:0]    rem;
    logic          out_valid;
    logic          out_ready;
    logic [16:0]   radical;
    logic          canonical;

    int checks = 0;
    int errors = 0;

    sqrt_square_recon #(.Q_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .remainder (rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .radical   (radical),
        .canonical (canonical)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one pair, wait for the result, check latency, busy ready, values, exit
    task automatic run_op(input logic [7:0] qv, input logic [8:0] rv,
                          input logic [16:0] erad, input logic ecan, input string tag);
        int lat;
        logic busy_ok;
        @(negedge clk);
        q         = qv;
        rem       = rv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        do begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end while (out_valid !== 1'b1 && lat < 20);
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(Q_W));
        chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
        chk({tag, "_radical"}, 32'(radical), 32'(erad));
        chk({tag, "_canonical"}, 32'(canonical), 32'(ecan));
        @(posedge clk);
        #1;
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic ov_seen;
        logic [17:0] expq[$];
        logic [17:0] e;
        int sent;
        int got;
        int cyc;
        logic fire_in;
        logic fire_out;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q         = '0;
        rem       = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_radical", 32'(radical), 32'd0);
        chk("rst_canonical", 32'(canonical), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic small products
        run_op(8'd2, 9'd0, 17'd4, 1'b1, "q2r0");
        run_op(8'd2, 9'd2, 17'd6, 1'b1, "q2r2");
        run_op(8'd3, 9'd0, 17'd9, 1'b1, "q3r0");
        run_op(8'd12, 9'd0, 17'd144, 1'b1, "q12r0");
        run_op(8'd146, 9'd233, 17'd21549, 1'b1, "q146r233");

        // Boundaries
        run_op(8'd255, 9'd511, 17'd65536, 1'b0, "qmax");
        run_op(8'd5, 9'd11, 17'd36, 1'b0, "q5r11");
        run_op(8'd5, 9'd10, 17'd35, 1'b1, "q5r10");
        run_op(8'd0, 9'd0, 17'd0, 1'b1, "q0r0");
        run_op(8'd0, 9'd3, 17'd3, 1'b0, "q0r3");

        // Backpressure: result held for 10 cycles, busy inputs ignored
        @(negedge clk);
        q = 8'd9; rem = 9'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (out_valid !== 1'b1 && lat < 20);
        chk("bp_latency", 32'(lat), 32'(Q_W));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            q        = 8'(i * 17);
            rem      = 9'(i * 31);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_radical", 32'(radical), 32'd82);
            chk("bp_canonical", 32'(canonical), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ov", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_single_hs", 32'(out_valid), 32'd0);

        // Reset in the middle of a multiply
        @(negedge clk);
        q = 8'd200; rem = 9'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_radical", 32'(radical), 32'd0);
        chk("mrst_canonical", 32'(canonical), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ov_seen = 1'b1;
        end
        chk("mrst_no_pulse", 32'(ov_seen), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        run_op(8'd7, 9'd3, 17'd52, 1'b1, "after_rst");

        // Random traffic with random valid/ready gaps, scoreboard in order
        sent = 0;
        got  = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (got < 2000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!in_valid && sent < 2000 && $urandom_range(0, 3) != 0) begin
                q        = 8'($urandom);
                rem      = 9'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            fire_in   = in_valid && in_ready;
            fire_out  = out_valid && out_ready;
            if (fire_out) begin
                if (expq.size() == 0) begin
                    chk("rand_spurious", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("rand_radical", 32'(radical), 32'(e[17:1]));
                    chk("rand_canonical", 32'(canonical), 32'(e[0]));
                end
                got++;
            end
            if (fire_in) begin
                expq.push_back({17'(q) * 17'(q) + 17'(rem), (9'(rem) <= {1'b0, q} + {1'b0, q})});
                sent++;
            end
            @(posedge clk);
            #1;
            if (fire_in) in_valid = 1'b0;
        end
        chk("rand_results", 32'(got), 32'd2000);
        chk("rand_leftover", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
